// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-channel mux select arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned HOLD_MAX_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT    = 3;

endpackage

// File: rtl/mux_select_arbiter_hold_counter.sv
// Saturating beat counter for one grant tenure; clr has priority over inc.
module hold_counter #(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/mux_select_arbiter.sv
// Two-channel round-robin arbiter driving the select of a downstream 2:1 mux,
// with each tenure capped at HOLD_MAX accepted beats while the other side waits.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic ready,
  output logic s0,
  output logic grant0,
  output logic grant1,
  output logic valid
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             s0_q, s0_d;
  logic [CNT_W-1:0] beat_cnt;
  logic             at_max;
  logic             accept;
  logic             cap_hit;
  logic             cnt_clr;

  assign grant0 = (state_q == ARB_GNT0);
  assign grant1 = (state_q == ARB_GNT1);
  assign s0     = s0_q;
  assign valid  = (grant0 & req0) | (grant1 & req1);
  assign accept = valid & ready;

  // The cap counts the beat accepted on this edge too, so a tenure under
  // contention is exactly HOLD_MAX accepted beats with no extra cycle.
  assign cap_hit = at_max | (accept & (beat_cnt == CNT_W'(HOLD_MAX - 1)));
  assign cnt_clr = (state_d != state_q);

  hold_counter #(
    .CNT_W   (CNT_W),
    .HOLD_MAX(HOLD_MAX)
  ) u_hold_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (accept),
    .cnt   (beat_cnt),
    .at_max(at_max)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? ARB_GNT0 : ARB_GNT1;
        end else if (req0) begin
          state_d = ARB_GNT0;
        end else if (req1) begin
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!req0) begin
          last_d  = 1'b0;
          state_d = req1 ? ARB_GNT1 : ARB_IDLE;
        end else if (req1 && cap_hit) begin
          last_d  = 1'b0;
          state_d = ARB_GNT1;
        end
      end
      ARB_GNT1: begin
        if (!req1) begin
          last_d  = 1'b1;
          state_d = req0 ? ARB_GNT0 : ARB_IDLE;
        end else if (req0 && cap_hit) begin
          last_d  = 1'b1;
          state_d = ARB_GNT0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    s0_d = s0_q;
    if (state_d == ARB_GNT1) begin
      s0_d = 1'b1;
    end else if (state_d == ARB_GNT0) begin
      s0_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      s0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s0_q    <= s0_d;
    end
  end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed and random stimulus for mux_select_arbiter, scored against a
// cycle-level reference model through an expected-output queue.
module tb_mux_select_arbiter;

  localparam int HM = 4;

  logic clk = 1'b0;
  logic rst, req0, req1, ready;
  logic s0, grant0, grant1, valid;

  typedef struct packed {
    logic g0;
    logic g1;
    logic s0;
  } exp_t;

  exp_t exp_q[$];

  int   m_state;  // 0 idle, 1 channel 0 granted, 2 channel 1 granted
  int   m_last;
  int   m_beats;
  logic m_s0;

  int checks   = 0;
  int failures = 0;
  int stepno   = 0;

  always #5 clk = ~clk;

  mux_select_arbiter #(
    .HOLD_MAX(4),
    .CNT_W   (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .ready (ready),
    .s0    (s0),
    .grant0(grant0),
    .grant1(grant1),
    .valid (valid)
  );

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0b expected=%0b", tag, stepno, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, stepno, obs, expv);
    end
  endtask

  task automatic model_step(input logic r, input logic q0, input logic q1, input logic rdy);
    int   x;
    int   nb;
    logic xr, yr;
    exp_t e;
    if (r) begin
      m_state = 0;
      m_last  = 1;
      m_beats = 0;
      m_s0    = 1'b0;
    end else if (m_state == 0) begin
      if (q0 && q1) m_state = (m_last == 1) ? 1 : 2;
      else if (q0)  m_state = 1;
      else if (q1)  m_state = 2;
      m_beats = 0;
    end else begin
      x  = m_state - 1;
      xr = (x == 0) ? q0 : q1;
      yr = (x == 0) ? q1 : q0;
      nb = (xr && rdy) ? ((m_beats < HM) ? m_beats + 1 : HM) : m_beats;
      if (!xr) begin
        m_last  = x;
        m_state = yr ? (2 - x) : 0;
        m_beats = 0;
      end else if (yr && (nb == HM)) begin
        m_last  = x;
        m_state = 2 - x;
        m_beats = 0;
      end else begin
        m_beats = nb;
      end
    end
    if (m_state == 2)      m_s0 = 1'b1;
    else if (m_state == 1) m_s0 = 1'b0;
    e.g0 = (m_state == 1);
    e.g1 = (m_state == 2);
    e.s0 = m_s0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic q0, input logic q1, input logic rdy);
    exp_t e;
    @(negedge clk);
    rst   = r;
    req0  = q0;
    req1  = q1;
    ready = rdy;
    model_step(r, q0, q1, rdy);
    @(posedge clk);
    #1;
    stepno++;
    if (exp_q.size() == 0) begin
      check_int("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_bit("grant0", grant0, e.g0);
      check_bit("grant1", grant1, e.g1);
      check_bit("s0", s0, e.s0);
      check_bit("valid", valid, (e.g0 & q0) | (e.g1 & q1));
      check_bit("grant_excl", grant0 & grant1, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog step=%0d observed=timeout expected=finish", stepno);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   run;
    logic prev;
    bit   seen_flip;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ready = 1'b0;
    m_state = 0; m_last = 1; m_beats = 0; m_s0 = 1'b0;

    // Reset with both requests pending, then channel 0 wins the first tie
    step(1, 1, 1, 1);
    check_bit("rst_valid", valid, 1'b0);
    step(1, 1, 1, 1);
    check_bit("rst_s0", s0, 1'b0);
    step(0, 1, 1, 1);
    check_bit("first_win0", grant0, 1'b1);

    // Channel 0 alone: counter saturates, then a late req1 switches at once
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
    check_bit("solo_hold", grant0, 1'b1);
    step(0, 1, 1, 1);
    check_bit("late_req1_switch", grant1, 1'b1);

    // Contention with ready always high: tenures of 4 cycles
    prev = s0;
    run  = 1;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 1);
      if (s0 == prev) run++;
      else begin
        check_int("tenure_ready1", run, 4);
        run  = 1;
        prev = s0;
      end
    end

    // Contention with ready on alternate cycles: tenures of 8 cycles
    seen_flip = 1'b0;
    prev = s0;
    run  = 1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, logic'(i % 2));
      if (s0 == prev) run++;
      else begin
        if (seen_flip) check_int("tenure_ready_alt", run, 8);
        seen_flip = 1'b1;
        run  = 1;
        prev = s0;
      end
    end

    // Release from channel 1 into idle; s0 holds, then channel 0 wins
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    check_bit("t5_in_gnt1", grant1, 1'b1);
    step(0, 0, 0, 1);
    check_bit("t5_idle_s0", s0, 1'b1);
    step(0, 0, 0, 1);
    step(0, 1, 1, 1);
    check_bit("t5_win0", grant0, 1'b1);

    // Reset in the middle of a channel 1 tenure
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(1, 0, 1, 1);
    check_bit("t6_rst_s0", s0, 1'b0);
    step(0, 1, 1, 1);
    check_bit("t6_restart_win0", grant0, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1);

    // Random traffic against the model
    for (int i = 0; i < 120; i++) begin
      step(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
